// File: rtl/imem_loader_if.sv
// Byte-stream in / word-write out bundle for imem_loader.
// csum_err exists only when IMEM_LOADER_CHECKSUM_EN is defined.
interface imem_loader_if #(
  parameter int DEPTH = 32
);
  localparam int WCW = $clog2(DEPTH) + 1;

  logic           start;
  logic           in_valid;
  logic [7:0]     in_data;
  logic           in_ready;
  logic           wr_en;
  logic [31:0]    wr_addr;
  logic [31:0]    wr_data;
  logic           busy;
  logic           done;
  logic           overflow;
  logic [WCW-1:0] word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic           csum_err;
`endif

  // master: host feeding bytes and watching status
  modport master (
    output start, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done, overflow, word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
    , input csum_err
`endif
  );

  // slave: the loader itself
  modport slave (
    input  start, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, busy, done, overflow, word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
    , output csum_err
`endif
  );
endinterface

// File: rtl/imem_loader.sv
// Assembles little-endian bytes into 32-bit words and writes them to the instruction store
// until the 0xFFFFFFFF marker. Optional trailing checksum byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int          DEPTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  imem_loader_if.slave bus
);
  localparam int          IW     = $clog2(DEPTH);
  localparam int          WCW    = IW + 1;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
  localparam logic [31:0] MARKER = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE
`ifdef IMEM_LOADER_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

  typedef struct packed {
    logic        en;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_req_t;

  state_t         state;
  logic [IW-1:0]  idx;
  logic [1:0]     lane;
  logic [31:0]    asm_word;
  logic [WCW-1:0] wc;
  logic           ovf, done_q, busy_q, rdy;
  wr_req_t        wr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]     csum;
  logic           csum_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      lane     <= '0;
      asm_word <= '0;
      wc       <= '0;
      ovf      <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      rdy      <= 1'b0;
      wr_q     <= '{en: 1'b0, addr: BASE_ADDR, data: 32'd0};
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
      csum_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state    <= RECV;
            idx      <= '0;
            lane     <= '0;
            wc       <= '0;
            ovf      <= 1'b0;
            asm_word <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
            rdy      <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
            csum_err_q <= 1'b0;
`endif
          end
        end
        RECV: begin
          if (bus.in_valid && rdy) begin
            asm_word[{lane, 3'b000} +: 8] <= bus.in_data;
            lane <= lane + 2'd1;
            if (lane == 2'd3) begin
              // the last slot always carries the marker so the reader terminates
              state     <= WRITE;
              rdy       <= 1'b0;
              wr_q.en   <= 1'b1;
              wr_q.addr <= BASE_ADDR + (32'(idx) << 2);
              wr_q.data <= (idx == LAST) ? MARKER : {bus.in_data, asm_word[23:0]};
              wc        <= wc + WCW'(1);
            end
          end
        end
        WRITE: begin
          wr_q.en <= 1'b0;
          if (asm_word == MARKER) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state <= CSUM;
            rdy   <= 1'b1;
`else
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
`endif
          end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum + asm_word[7:0] + asm_word[15:8] + asm_word[23:16] + asm_word[31:24];
`endif
            if (idx == LAST) begin
              state  <= DONE;
              ovf    <= 1'b1;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state <= RECV;
              idx   <= idx + IW'(1);
              lane  <= '0;
              rdy   <= 1'b1;
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (bus.in_valid && rdy) begin
            csum_err_q <= (bus.in_data != csum);
            state      <= DONE;
            rdy        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = rdy;
  assign bus.wr_en      = wr_q.en;
  assign bus.wr_addr    = wr_q.addr;
  assign bus.wr_data    = wr_q.data;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.overflow   = ovf;
  assign bus.word_count = wc;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign bus.csum_err   = csum_err_q;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader (DEPTH=32 and DEPTH=4 instances) against a word-list model.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.DEPTH(32)) a32();
  imem_loader_if #(.DEPTH(4))  a4();

  imem_loader #(.DEPTH(32), .BASE_ADDR(32'd0)) u32 (.clk(clk), .rst_n(rst_n), .bus(a32.slave));
  imem_loader #(.DEPTH(4),  .BASE_ADDR(32'd0)) u4  (.clk(clk), .rst_n(rst_n), .bus(a4.slave));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int viol  = 0;

  logic [31:0] ga32[$], gd32[$], ga4[$], gd4[$];
  int          gt32[$], gt4[$];

  // write-port capture, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (a32.wr_en) begin
      ga32.push_back(a32.wr_addr); gd32.push_back(a32.wr_data); gt32.push_back(cyc);
      if (a32.in_ready) viol++;
    end
    if (a4.wr_en) begin
      ga4.push_back(a4.wr_addr); gd4.push_back(a4.wr_data); gt4.push_back(cyc);
      if (a4.in_ready) viol++;
    end
  end

  // reference: the write list is just the byte stream cut into words
  logic [7:0]  byte_q[$];
  logic [31:0] ea[$], ed[$];
  logic        eovf;
  logic [7:0]  esum;
`ifdef IMEM_LOADER_CHECKSUM_EN
  int csum_ovr = -1;
`endif

  task automatic model(input int depth);
    logic [31:0] w;
    ea.delete(); ed.delete(); eovf = 1'b0; esum = 8'd0;
    for (int i = 0; i*4+3 < byte_q.size(); i++) begin
      w = {byte_q[4*i+3], byte_q[4*i+2], byte_q[4*i+1], byte_q[4*i]};
      ea.push_back(32'(4*i));
      if (i == depth-1) begin
        ed.push_back(32'hFFFF_FFFF);
        eovf = (w != 32'hFFFF_FFFF);
        break;
      end
      ed.push_back(w);
      if (w == 32'hFFFF_FFFF) break;
      esum = esum + w[7:0] + w[15:8] + w[23:16] + w[31:24];
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit sel, input logic s, input logic v, input logic [7:0] d);
    if (sel) begin a4.start = s; a4.in_valid = v; a4.in_data = d; end
    else     begin a32.start = s; a32.in_valid = v; a32.in_data = d; end
  endtask

  task automatic snap(input bit sel, output logic rdy, output logic wen, output logic bsy,
                      output logic dn, output logic ovf, output logic [31:0] addr,
                      output logic [31:0] data, output logic [5:0] wc);
    if (sel) begin
      rdy = a4.in_ready; wen = a4.wr_en; bsy = a4.busy; dn = a4.done; ovf = a4.overflow;
      addr = a4.wr_addr; data = a4.wr_data; wc = 6'(a4.word_count);
    end else begin
      rdy = a32.in_ready; wen = a32.wr_en; bsy = a32.busy; dn = a32.done; ovf = a32.overflow;
      addr = a32.wr_addr; data = a32.wr_data; wc = a32.word_count;
    end
  endtask

  task automatic clear_q(input bit sel);
    if (sel) begin ga4.delete(); gd4.delete(); gt4.delete(); end
    else     begin ga32.delete(); gd32.delete(); gt32.delete(); end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) byte_q.push_back(w[8*k +: 8]);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w = $urandom;
    if (w == 32'hFFFF_FFFF) w = 32'd0;
    return w;
  endfunction

  // present one byte; it is taken on the edge after a negedge that sees in_ready
  task automatic send_byte(input bit sel, input logic [7:0] b, input int maxgap);
    logic rdy, wen, bsy, dn, ovf; logic [31:0] ad, da; logic [5:0] wc;
    int g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    repeat (g) begin @(negedge clk); set_in(sel, 1'b0, 1'b0, 8'h00); end
    for (int n = 0; ; n++) begin
      @(negedge clk);
      set_in(sel, 1'b0, 1'b1, b);
      snap(sel, rdy, wen, bsy, dn, ovf, ad, da, wc);
      if (rdy) break;
      if (n > 200) begin chk("accept_timeout", 64'd0, 64'd1); break; end
    end
  endtask

  task automatic idle(input bit sel);
    @(negedge clk); set_in(sel, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic pulse_start(input bit sel);
    @(negedge clk); set_in(sel, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic wait_done(input bit sel);
    logic rdy, wen, bsy, dn, ovf; logic [31:0] ad, da; logic [5:0] wc;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      snap(sel, rdy, wen, bsy, dn, ovf, ad, da, wc);
      if (dn) return;
    end
    chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_tail(input bit sel, input int maxgap);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (!eovf) send_byte(sel, (csum_ovr >= 0) ? 8'(csum_ovr) : esum, maxgap);
`else
    if (sel && maxgap < 0) idle(sel);
`endif
  endtask

  task automatic run_load(input bit sel, input int maxgap, input int depth);
    clear_q(sel);
    model(depth);
    pulse_start(sel);
    foreach (byte_q[i]) send_byte(sel, byte_q[i], maxgap);
    send_tail(sel, maxgap);
    idle(sel);
    wait_done(sel);
  endtask

  task automatic check_load(input bit sel, input string tag);
    logic rdy, wen, bsy, dn, ovf; logic [31:0] ad, da; logic [5:0] wc;
    int n = sel ? ga4.size() : ga32.size();
    chk({tag, "_nwr"}, 64'(n), 64'(ea.size()));
    for (int i = 0; i < ea.size(); i++) begin
      chk({tag, "_addr"}, (i < n) ? 64'(sel ? ga4[i] : ga32[i]) : 64'hDEAD, 64'(ea[i]));
      chk({tag, "_data"}, (i < n) ? 64'(sel ? gd4[i] : gd32[i]) : 64'hDEAD, 64'(ed[i]));
    end
    snap(sel, rdy, wen, bsy, dn, ovf, ad, da, wc);
    chk({tag, "_wc"},   64'(wc),  64'(ea.size()));
    chk({tag, "_ovf"},  64'(ovf), 64'(eovf));
    chk({tag, "_done"}, 64'(dn),  64'd1);
    chk({tag, "_busy"}, 64'(bsy), 64'd0);
    chk({tag, "_rdy"},  64'(rdy), 64'd0);
  endtask

  task automatic check_reset(input bit sel, input string tag);
    logic rdy, wen, bsy, dn, ovf; logic [31:0] ad, da; logic [5:0] wc;
    snap(sel, rdy, wen, bsy, dn, ovf, ad, da, wc);
    chk({tag, "_rdy"},  64'(rdy), 64'd0);
    chk({tag, "_wen"},  64'(wen), 64'd0);
    chk({tag, "_addr"}, 64'(ad),  64'd0);
    chk({tag, "_data"}, 64'(da),  64'd0);
    chk({tag, "_busy"}, 64'(bsy), 64'd0);
    chk({tag, "_done"}, 64'(dn),  64'd0);
    chk({tag, "_ovf"},  64'(ovf), 64'd0);
    chk({tag, "_wc"},   64'(wc),  64'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk({tag, "_cerr"}, 64'(sel ? a4.csum_err : a32.csum_err), 64'd0);
`endif
  endtask

  initial begin
    logic rdy, wen, bsy, dn, ovf; logic [31:0] ad, da; logic [5:0] wc;
    set_in(1'b0, 1'b0, 1'b0, 8'h00);
    set_in(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    check_reset(1'b0, "rst32");
    check_reset(1'b1, "rst4");
    rst_n = 1'b1;

    // basic program
    byte_q = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
               8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_load(1'b0, 0, 32);
    check_load(1'b0, "basic");
    chk("basic_w0", 64'(gd32.size() > 0 ? gd32[0] : 32'h0), 64'h0050_0013);
    chk("basic_w1", 64'(gd32.size() > 1 ? gd32[1] : 32'h0), 64'h0010_0093);
    chk("basic_a2", 64'(ga32.size() > 2 ? ga32[2] : 32'h0), 64'd8);

    // back-to-back: one word per 5 edges, never ready during a write
    byte_q.delete();
    repeat (3) push_word(rand_word());
    push_word(32'hFFFF_FFFF);
    run_load(1'b0, 0, 32);
    check_load(1'b0, "tput");
    for (int i = 0; i + 1 < gt32.size(); i++) chk("tput_gap", 64'(gt32[i+1] - gt32[i]), 64'd5);
    chk("tput_rdy_in_write", 64'(viol), 64'd0);

    // random valid gaps
    for (int r = 0; r < 3; r++) begin
      byte_q.delete();
      repeat (2 + r*2) push_word(rand_word());
      push_word(32'hFFFF_FFFF);
      run_load(1'b0, 3, 32);
      check_load(1'b0, "gaps");
    end

    // overflow on the small store
    byte_q.delete();
    repeat (4) push_word(32'h1111_1111);
    run_load(1'b1, 1, 4);
    check_load(1'b1, "ovf");
    chk("ovf_flag", 64'(a4.overflow), 64'd1);
    chk("ovf_last", 64'(gd4.size() > 3 ? gd4[3] : 32'h0), 64'hFFFF_FFFF);

    // marker landing exactly in the last slot is not an overflow
    byte_q.delete();
    repeat (3) push_word(rand_word());
    push_word(32'hFFFF_FFFF);
    run_load(1'b1, 2, 4);
    check_load(1'b1, "lastmark");

    // reset after two bytes of a word
    clear_q(1'b0);
    pulse_start(1'b0);
    send_byte(1'b0, 8'hAA, 0);
    send_byte(1'b0, 8'hBB, 0);
    idle(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_nwr", 64'(ga32.size()), 64'd0);
    check_reset(1'b0, "midrst");
    @(negedge clk);
    rst_n = 1'b1;
    byte_q = '{8'h13, 8'h00, 8'h50, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_load(1'b0, 1, 32);
    check_load(1'b0, "afterrst");

    // start while busy is ignored
    byte_q.delete();
    repeat (3) push_word(rand_word());
    push_word(32'hFFFF_FFFF);
    clear_q(1'b0);
    model(32);
    pulse_start(1'b0);
    for (int i = 0; i < 5; i++) send_byte(1'b0, byte_q[i], 0);
    pulse_start(1'b0);
    idle(1'b0);
    snap(1'b0, rdy, wen, bsy, dn, ovf, ad, da, wc);
    chk("busystart_wc", 64'(wc), 64'd1);
    chk("busystart_busy", 64'(bsy), 64'd1);
    for (int i = 5; i < byte_q.size(); i++) send_byte(1'b0, byte_q[i], 1);
    send_tail(1'b0, 0);
    idle(1'b0);
    wait_done(1'b0);
    check_load(1'b0, "busystart");

    // start from DONE restarts cleanly
    pulse_start(1'b0);
    idle(1'b0);
    snap(1'b0, rdy, wen, bsy, dn, ovf, ad, da, wc);
    chk("restart_done", 64'(dn), 64'd0);
    chk("restart_wc", 64'(wc), 64'd0);
    chk("restart_busy", 64'(bsy), 64'd1);
    chk("restart_rdy", 64'(rdy), 64'd1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;

`ifdef IMEM_LOADER_CHECKSUM_EN
    byte_q = '{8'h13, 8'h00, 8'h50, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    csum_ovr = 8'h63;
    run_load(1'b0, 0, 32);
    check_load(1'b0, "csum_ok");
    chk("csum_ok_err", 64'(a32.csum_err), 64'd0);
    csum_ovr = 8'h64;
    run_load(1'b0, 0, 32);
    check_load(1'b0, "csum_bad");
    chk("csum_bad_err", 64'(a32.csum_err), 64'd1);
    csum_ovr = -1;
    byte_q.delete();
    repeat (4) push_word(32'h2222_2222);
    run_load(1'b1, 0, 4);
    chk("csum_ovf_err", 64'(a4.csum_err), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream loader that fills the instruction memory before the core runs. It accepts a stream of program bytes over a valid/ready handshake and assembles each group of four bytes into a little-endian 32-bit word. Each word is written through a word-wide write port into the instruction store at consecutive byte addresses, and loading ends on the 0xFFFFFFFF end-of-program marker. It is the write-side counterpart of the instruction memory's byte-addressed little-endian read path and its 0xFFFFFFFF last-instruction detection.

## Interface
- DEPTH, 32: instruction store size in 32-bit words; slot DEPTH-1 is reserved for the marker.
- BASE_ADDR, 32'd0: byte address of word 0; must be a multiple of 4.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
- in_valid  input  1  in_data holds a program byte.
- in_data  input  8  program byte, least-significant byte of each word first.
- in_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  one-cycle word write strobe.
- wr_addr  output  32  byte address of the write: BASE_ADDR + 4*index.
- wr_data  output  32  assembled word, {b3,b2,b1,b0}.
- busy  output  1  a load is in progress.
- done  output  1  load finished; held high until the next start or reset.
- overflow  output  1  the store filled before a marker arrived; valid while done is high.
- word_count  output  $clog2(DEPTH)+1  words written so far, marker included.

## Operation
- States: IDLE, RECV, WRITE, DONE, plus CSUM when the checksum option is compiled in.
- IDLE/DONE + start -> RECV:
  - clears index, byte lane, word_count, overflow and the assembly register;
  - done drops in the same cycle the state leaves DONE.
- RECV:
  - in_ready=1.
  - A byte is accepted on each edge with in_valid&&in_ready.
  - Byte k (k=0..3) goes into bits [8k+7:8k].
  - Acceptance of byte 3 -> WRITE.
- WRITE:
  - wr_en=1, in_ready=0, wr_addr=BASE_ADDR+4*index.
  - wr_data is the assembled word, except that at index DEPTH-1 it is forced to 0xFFFFFFFF.
  - word_count increments by one.
- Transition out of WRITE, first match wins:
  - assembled word == 0xFFFFFFFF -> DONE (or CSUM);
  - index == DEPTH-1 and the word was not the marker -> overflow=1, DONE;
  - otherwise index+1 -> RECV.
- A marker received exactly at slot DEPTH-1 is not an overflow.
- Index arithmetic is unsigned with no wrap. Index never exceeds DEPTH-1 and word_count never exceeds DEPTH.
- start while busy is ignored.
- in_valid outside RECV/CSUM is ignored; no bytes are consumed.
- Reset mid-load:
  - any partial word is discarded;
  - no write is issued;
  - the state returns to IDLE.

## Timing
- Reset values: in_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, busy=0, done=0, overflow=0, word_count=0. The state is IDLE.
- busy is high in RECV, WRITE and CSUM.
- Latency from acceptance of byte 3 to wr_en is exactly 1 cycle.
- wr_en is high for exactly 1 cycle per word.
- With in_valid held high, the peak rate is one word every 5 cycles: 4 accept cycles plus 1 write cycle.
- done rises in the cycle after the final WRITE, or after the final CSUM accept when the checksum option is present.
- in_ready is registered and changes only on clock edges. The source may hold in_valid indefinitely; the loader never drops a byte that is presented while in_ready is high.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - adds the output csum_err (1 bit, reset 0), which is valid while done is high;
  - the loader keeps an 8-bit modulo-256 sum of every accepted byte of non-marker words;
  - after the marker WRITE it enters CSUM with in_ready=1 and accepts one byte;
  - csum_err = (byte != sum), then the state goes to DONE;
  - on overflow, CSUM is skipped and csum_err=0.
- IMEM_LOADER_CHECKSUM_EN undefined: there is no csum_err port and no CSUM state; the marker WRITE goes directly to DONE.

## Test plan
- Basic load, DEPTH=32, BASE_ADDR=0:
  - stream 13 00 50 00, 93 00 10 00, FF FF FF FF;
  - -> writes 0x00500013 @0, 0x00100093 @4, 0xFFFFFFFF @8;
  - word_count=3, done=1, overflow=0.
- Throughput and backpressure:
  - with in_valid held high, measure edges between successive wr_en pulses -> 5; in_ready=0 in every WRITE cycle;
  - with in_valid toggled randomly, the written data is unchanged.
- Overflow, DEPTH=4, no marker in the stream:
  - stream 4 words of 0x11111111 -> writes @0,@4,@8 = 0x11111111 and @12 = 0xFFFFFFFF;
  - overflow=1, word_count=4, in_ready=0 afterward.
- Reset mid-word:
  - assert rst_n=0 after 2 bytes -> no wr_en, all outputs return to their reset values;
  - a fresh start plus a full stream loads from address 0.
- start ignored while busy:
  - pulse start after 5 bytes -> index and word_count continue unaffected;
  - start in DONE restarts the load with done=0 and word_count=0.
- Checksum (macro defined):
  - stream 13 00 50 00, FF FF FF FF, then 63 -> csum_err=0;
  - repeat with 64 as the final byte -> csum_err=1.
